// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: line codes, FSM states, error word and bit-period helpers.
package uart_pkg;

    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] PARITY_NONE     = 2'b00;
    localparam logic [1:0] PARITY_ODD      = 2'b01;
    localparam logic [1:0] PARITY_EVEN     = 2'b10;
    localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    typedef struct packed {
        logic stop_err;
        logic start_err;
        logic parity_err;
    } rx_err_t;

    // Clock cycles per bit, truncated.
    function automatic logic [CNT_W-1:0] bit_period(input int unsigned clk_freq,
                                                    input logic [1:0] baud);
        int unsigned rate;
        case (baud)
            BAUD_2400: rate = 2400;
            BAUD_4800: rate = 4800;
            BAUD_9600: rate = 9600;
            default:   rate = 19200;
        endcase
        return CNT_W'(clk_freq / rate);
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
    endfunction

    function automatic logic parity_bit(input logic [1:0] mode, input logic [7:0] data);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period tick generator: reloadable down-counter, first period optionally halved for mid-bit sampling.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             half,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    output logic             tick_c
);

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] count_q;

    // Period is captured on load so baud changes only apply at the next frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            period_q <= '0;
            count_q  <= '0;
        end else if (load) begin
            period_q <= period;
            count_q  <= half ? (period >> 1) : period;
        end else if (enable) begin
            if (count_q <= CNT_W'(1))
                count_q <= period_q;
            else
                count_q <= count_q - CNT_W'(1);
        end
    end

    assign tick_c = enable && (count_q == CNT_W'(1));

endmodule

// File: rtl/uart_txrx_unit.sv
// Full-duplex 8-bit UART: independent TX and RX frame FSMs sharing parity/baud selection.
module uart_txrx_unit
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    input  logic       tx_send,
    input  logic [7:0] tx_data_in,
    output logic       tx_serial,
    output logic       tx_active_flag,
    output logic       tx_done_flag,
    input  logic       rx_serial,
    output logic [7:0] rx_data_out,
    output logic [2:0] rx_error_flag,
    output logic       rx_active_flag,
    output logic       rx_done_flag
);

    logic [CNT_W-1:0] period_sel;
    assign period_sel = bit_period(CLK_FREQ, baud_rate);

    // ---------------- transmitter ----------------
    uart_state_e tx_state_q, tx_state_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_data_q;
    logic [1:0]  tx_par_q;
    logic        tx_load, tx_tick_c;
    logic        tx_serial_d, tx_active_d, tx_done_d;

    uart_bit_timer u_tx_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (tx_load),
        .half   (1'b0),
        .enable (tx_state_q != ST_IDLE),
        .period (period_sel),
        .tick_c (tx_tick_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q     <= ST_IDLE;
            tx_idx_q       <= '0;
            tx_data_q      <= '0;
            tx_par_q       <= PARITY_NONE;
            tx_serial      <= 1'b1;
            tx_active_flag <= 1'b0;
            tx_done_flag   <= 1'b0;
        end else begin
            tx_state_q     <= tx_state_d;
            tx_idx_q       <= tx_idx_d;
            tx_serial      <= tx_serial_d;
            tx_active_flag <= tx_active_d;
            tx_done_flag   <= tx_done_d;
            if (tx_load) begin
                tx_data_q <= tx_data_in;
                tx_par_q  <= parity_type;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_idx_d   = tx_idx_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            ST_IDLE: if (tx_send) begin
                tx_state_d = ST_START;
                tx_load    = 1'b1;
            end
            ST_START: if (tx_tick_c) begin
                tx_state_d = ST_DATA;
                tx_idx_d   = '0;
            end
            ST_DATA: if (tx_tick_c) begin
                if (tx_idx_q == 3'd7)
                    tx_state_d = parity_enabled(tx_par_q) ? ST_PARITY : ST_STOP;
                else
                    tx_idx_d = tx_idx_q + 3'd1;
            end
            ST_PARITY: if (tx_tick_c) tx_state_d = ST_STOP;
            ST_STOP:   if (tx_tick_c) tx_state_d = ST_IDLE;
            default:   tx_state_d = ST_IDLE;
        endcase
    end

    // Line level follows the state being entered so it is registered with the state.
    always_comb begin
        tx_serial_d = 1'b1;
        tx_active_d = (tx_state_d != ST_IDLE);
        tx_done_d   = (tx_state_q == ST_STOP) && tx_tick_c;
        case (tx_state_d)
            ST_START:  tx_serial_d = 1'b0;
            ST_DATA:   tx_serial_d = tx_data_q[tx_idx_d];
            ST_PARITY: tx_serial_d = parity_bit(tx_par_q, tx_data_q);
            default:   tx_serial_d = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    uart_state_e rx_state_q, rx_state_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_shift_q;
    logic [1:0]  rx_par_q;
    logic        rx_par_bit_q;
    logic        rx_s1, rx_s2, rx_s3;
    logic        rx_load, rx_tick_c;
    logic        rx_active_d, rx_done_d;
    logic [7:0]  rx_data_d;
    rx_err_t     rx_err_d;

    uart_bit_timer u_rx_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (rx_load),
        .half   (1'b1),
        .enable (rx_state_q != ST_IDLE),
        .period (period_sel),
        .tick_c (rx_tick_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            {rx_s1, rx_s2, rx_s3} <= 3'b111;
            rx_state_q     <= ST_IDLE;
            rx_idx_q       <= '0;
            rx_shift_q     <= '0;
            rx_par_q       <= PARITY_NONE;
            rx_par_bit_q   <= 1'b0;
            rx_data_out    <= '0;
            rx_error_flag  <= '0;
            rx_active_flag <= 1'b0;
            rx_done_flag   <= 1'b0;
        end else begin
            {rx_s1, rx_s2, rx_s3} <= {rx_serial, rx_s1, rx_s2};
            rx_state_q     <= rx_state_d;
            rx_idx_q       <= rx_idx_d;
            rx_data_out    <= rx_data_d;
            rx_error_flag  <= rx_err_d;
            rx_active_flag <= rx_active_d;
            rx_done_flag   <= rx_done_d;
            if (rx_load)
                rx_par_q <= parity_type;
            if ((rx_state_q == ST_DATA) && rx_tick_c)
                rx_shift_q <= {rx_s2, rx_shift_q[7:1]};
            if ((rx_state_q == ST_PARITY) && rx_tick_c)
                rx_par_bit_q <= rx_s2;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_idx_d   = rx_idx_q;
        rx_load    = 1'b0;
        case (rx_state_q)
            ST_IDLE: if (rx_s3 && !rx_s2) begin
                rx_state_d = ST_START;
                rx_load    = 1'b1;
            end
            ST_START: if (rx_tick_c) begin
                rx_state_d = rx_s2 ? ST_IDLE : ST_DATA;
                rx_idx_d   = '0;
            end
            ST_DATA: if (rx_tick_c) begin
                if (rx_idx_q == 3'd7)
                    rx_state_d = parity_enabled(rx_par_q) ? ST_PARITY : ST_STOP;
                else
                    rx_idx_d = rx_idx_q + 3'd1;
            end
            ST_PARITY: if (rx_tick_c) rx_state_d = ST_STOP;
            ST_STOP:   if (rx_tick_c) rx_state_d = ST_IDLE;
            default:   rx_state_d = ST_IDLE;
        endcase
    end

    // Error word and data only change on an aborted start or at the stop sample.
    always_comb begin
        rx_active_d = (rx_state_d != ST_IDLE);
        rx_done_d   = (rx_state_q == ST_STOP) && rx_tick_c;
        rx_data_d   = rx_data_out;
        rx_err_d    = rx_err_t'(rx_error_flag);
        if ((rx_state_q == ST_START) && rx_tick_c && rx_s2)
            rx_err_d = '{stop_err: 1'b0, start_err: 1'b1, parity_err: 1'b0};
        if (rx_done_d) begin
            rx_data_d           = rx_shift_q;
            rx_err_d.stop_err   = ~rx_s2;
            rx_err_d.start_err  = 1'b0;
            rx_err_d.parity_err = parity_enabled(rx_par_q) &&
                                  (rx_par_bit_q != parity_bit(rx_par_q, rx_shift_q));
        end
    end

endmodule

// File: tb/tb_uart_txrx_unit.sv
// Directed plus randomized bench for uart_txrx_unit, run at a reduced clock so bit periods stay short.
module tb_uart_txrx_unit;

    localparam int unsigned CLK_FREQ = 192_000;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] parity_type, baud_rate;
    logic       tx_send;
    logic [7:0] tx_data_in;
    logic       tx_serial, tx_active_flag, tx_done_flag;
    logic       rx_serial;
    logic [7:0] rx_data_out;
    logic [2:0] rx_error_flag;
    logic       rx_active_flag, rx_done_flag;
    logic       loop_en, rx_drv;

    int ncmp = 0;
    int nfail = 0;

    assign rx_serial = loop_en ? tx_serial : rx_drv;

    always #5 clock = ~clock;

    uart_txrx_unit #(.CLK_FREQ(CLK_FREQ)) dut (
        .clock          (clock),
        .reset          (reset),
        .parity_type    (parity_type),
        .baud_rate      (baud_rate),
        .tx_send        (tx_send),
        .tx_data_in     (tx_data_in),
        .tx_serial      (tx_serial),
        .tx_active_flag (tx_active_flag),
        .tx_done_flag   (tx_done_flag),
        .rx_serial      (rx_serial),
        .rx_data_out    (rx_data_out),
        .rx_error_flag  (rx_error_flag),
        .rx_active_flag (rx_active_flag),
        .rx_done_flag   (rx_done_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int period_of(input logic [1:0] b);
        int rate;
        case (b)
            2'd0:    rate = 2400;
            2'd1:    rate = 4800;
            2'd2:    rate = 9600;
            default: rate = 19200;
        endcase
        return int'(CLK_FREQ) / rate;
    endfunction

    // Reference frame: start, data LSB first, optional parity, stop.
    function automatic int build_frame(input logic [7:0] d, input logic [1:0] p,
                                       output logic [10:0] fb);
        int ones;
        ones = $countones(d);
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
        if (p == 2'b01 || p == 2'b10) begin
            fb[9] = (p == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
            return 11;
        end
        return 10;
    endfunction

    // Transmit one byte looped back into RX, checking every mid-bit level and the done timing.
    task automatic run_tx(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                          input string tag);
        logic [10:0] fb;
        logic [7:0]  rx_d;
        logic [2:0]  rx_e;
        int nb, n, done_t, done_cnt, rx_cnt;
        bit act_ok;
        n = period_of(b);
        nb = build_frame(d, p, fb);
        rx_d = 8'h00; rx_e = 3'b111;
        done_t = -1; done_cnt = 0; rx_cnt = 0; act_ok = 1'b1;
        loop_en = 1'b1;
        @(negedge clock);
        tx_data_in = d; parity_type = p; baud_rate = b; tx_send = 1'b1;
        @(negedge clock);
        tx_send = 1'b0;
        tx_data_in = ~d;
        for (int t = 0; t <= nb * n + 4; t++) begin
            if (t > 0) @(negedge clock);
            if (t < nb * n) begin
                if (!tx_active_flag) act_ok = 1'b0;
                if (t % n == n / 2)
                    check($sformatf("%s line bit%0d", tag, t / n), 32'(tx_serial), 32'(fb[t / n]));
            end
            if (tx_done_flag) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            if (rx_done_flag) begin
                rx_cnt++;
                rx_d = rx_data_out;
                rx_e = rx_error_flag;
            end
        end
        check({tag, " tx_done count"}, 32'(done_cnt), 32'd1);
        check({tag, " tx_done time"}, 32'(done_t), 32'(nb * n));
        check({tag, " active held"}, 32'(act_ok), 32'd1);
        check({tag, " active low after"}, 32'(tx_active_flag), 32'd0);
        check({tag, " rx_done count"}, 32'(rx_cnt), 32'd1);
        check({tag, " rx data"}, 32'(rx_d), 32'(d));
        check({tag, " rx err"}, 32'(rx_e), 32'd0);
    endtask

    // Bit-bang a frame on rx_serial, collecting any done pulse.
    task automatic rx_send(input logic [10:0] fb, input int nb, input int n,
                           output int dones, output logic [7:0] dat, output logic [2:0] err);
        dones = 0; dat = 8'h00; err = 3'b111;
        for (int k = 0; k <= nb; k++) begin
            rx_drv = (k < nb) ? fb[k] : 1'b1;
            for (int c = 0; c < n; c++) begin
                @(negedge clock);
                if (rx_done_flag) begin
                    dones++;
                    dat = rx_data_out;
                    err = rx_error_flag;
                end
            end
        end
    endtask

    initial begin
        logic [10:0] fb;
        logic [7:0]  d, dat;
        logic [2:0]  err;
        logic [1:0]  p, b;
        logic [7:0]  got [2];
        logic [2:0]  gerr [2];
        int nb, n, dones, txd, rxc;

        reset = 1'b1; tx_send = 1'b0; tx_data_in = 8'h00;
        parity_type = 2'b00; baud_rate = 2'b00; rx_drv = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge clock);
        check("reset tx_serial", 32'(tx_serial), 32'd1);
        check("reset flags", 32'({tx_active_flag, tx_done_flag, rx_active_flag, rx_done_flag}), 32'd0);
        check("reset rx_data", 32'(rx_data_out), 32'd0);
        check("reset rx_err", 32'(rx_error_flag), 32'd0);
        reset = 1'b0;

        run_tx(8'h53, 2'b01, 2'b10, "odd9600");
        run_tx(8'hA5, 2'b00, 2'b00, "none2400");

        // Back-to-back loopback with tx_send held high.
        n = period_of(2'b11);
        loop_en = 1'b1; txd = 0; rxc = 0;
        got[0] = 8'h00; got[1] = 8'h00; gerr[0] = 3'b111; gerr[1] = 3'b111;
        @(negedge clock);
        parity_type = 2'b10; baud_rate = 2'b11; tx_data_in = 8'h3A; tx_send = 1'b1;
        for (int t = 0; t < 30 * n && rxc < 2; t++) begin
            @(negedge clock);
            if (tx_active_flag && txd == 0) tx_data_in = 8'h0A;
            if (tx_done_flag) txd++;
            if (txd == 1 && tx_active_flag) tx_send = 1'b0;
            if (rx_done_flag) begin
                got[rxc] = rx_data_out;
                gerr[rxc] = rx_error_flag;
                rxc++;
            end
        end
        tx_send = 1'b0;
        for (int t = 0; t < 3 * n; t++) begin
            @(negedge clock);
            if (tx_done_flag) txd++;
        end
        check("b2b rx count", 32'(rxc), 32'd2);
        check("b2b rx byte0", 32'(got[0]), 32'h3A);
        check("b2b rx byte1", 32'(got[1]), 32'h0A);
        check("b2b rx err", 32'({gerr[0], gerr[1]}), 32'd0);
        check("b2b tx done count", 32'(txd), 32'd2);

        // Parity error: odd parity on 0x30 with the parity bit forced low.
        loop_en = 1'b0;
        parity_type = 2'b01; baud_rate = 2'b10;
        n = period_of(2'b10);
        nb = build_frame(8'h30, 2'b01, fb);
        check("par model bit", 32'(fb[9]), 32'd1);
        fb[9] = 1'b0;
        rx_send(fb, nb, n, dones, dat, err);
        check("parerr done", 32'(dones), 32'd1);
        check("parerr data", 32'(dat), 32'h30);
        check("parerr err", 32'(err), 32'b001);

        // Short low glitch: start error, no done, back to idle.
        parity_type = 2'b00;
        dones = 0;
        @(negedge clock);
        rx_drv = 1'b0;
        repeat (4) @(negedge clock);
        check("glitch active", 32'(rx_active_flag), 32'd1);
        rx_drv = 1'b1;
        for (int t = 0; t < 3 * n; t++) begin
            @(negedge clock);
            if (rx_done_flag) dones++;
        end
        check("glitch no done", 32'(dones), 32'd0);
        check("glitch err", 32'(rx_error_flag), 32'b010);
        check("glitch idle", 32'(rx_active_flag), 32'd0);
        nb = build_frame(8'h4C, 2'b00, fb);
        rx_send(fb, nb, n, dones, dat, err);
        check("after glitch done", 32'(dones), 32'd1);
        check("after glitch data", 32'(dat), 32'h4C);
        check("after glitch err", 32'(err), 32'b000);

        // Randomized RX frames and TX loopback frames.
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            p = 2'($urandom_range(0, 3));
            b = 2'($urandom_range(0, 3));
            parity_type = p; baud_rate = b;
            nb = build_frame(d, p, fb);
            rx_send(fb, nb, period_of(b), dones, dat, err);
            check($sformatf("rand rx%0d done", i), 32'(dones), 32'd1);
            check($sformatf("rand rx%0d data", i), 32'(dat), 32'(d));
            check($sformatf("rand rx%0d err", i), 32'(err), 32'd0);
        end
        for (int i = 0; i < 2; i++)
            run_tx(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   $sformatf("rand tx%0d", i));

        // Stop-bit error on an even-parity frame.
        loop_en = 1'b0;
        parity_type = 2'b10; baud_rate = 2'b11;
        nb = build_frame(8'hC3, 2'b10, fb);
        fb[nb-1] = 1'b0;
        rx_send(fb, nb, period_of(2'b11), dones, dat, err);
        check("stoperr done", 32'(dones), 32'd1);
        check("stoperr data", 32'(dat), 32'hC3);
        check("stoperr err", 32'(err), 32'b100);

        // Reset in the middle of a TX frame and an RX frame.
        parity_type = 2'b01; baud_rate = 2'b10;
        n = period_of(2'b10);
        @(negedge clock);
        tx_data_in = 8'h00; tx_send = 1'b1; rx_drv = 1'b0;
        @(negedge clock);
        tx_send = 1'b0;
        repeat (3 * n) @(negedge clock);
        check("mid tx active", 32'(tx_active_flag), 32'd1);
        check("mid rx active", 32'(rx_active_flag), 32'd1);
        reset = 1'b1; rx_drv = 1'b1;
        @(negedge clock);
        check("midreset tx_serial", 32'(tx_serial), 32'd1);
        check("midreset flags", 32'({tx_active_flag, tx_done_flag, rx_active_flag, rx_done_flag}), 32'd0);
        check("midreset rx_data", 32'(rx_data_out), 32'd0);
        check("midreset rx_err", 32'(rx_error_flag), 32'd0);
        reset = 1'b0;
        run_tx(8'h96, 2'b10, 2'b01, "post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
